// File: rtl/cplx_q15_mac_pkg.sv
// Q15 fixed-point types shared by the complex MAC datapath.
// Holds the partial-product type, the Q15 limits and the saturating narrowing helper.
package Q15Types;

    typedef logic signed [15:0] Q15;

    typedef struct packed {
        Q15 re;
        Q15 im;
    } CplxQ15;

    typedef logic signed [31:0] Q30P;

    localparam Q15 Q15_MAX = 16'sh7FFF;
    localparam Q15 Q15_MIN = 16'sh8000;

    // Widest value satQ15 accepts; callers sign-extend narrower operands up to this.
    localparam int unsigned SAT_W = 64;

    typedef struct packed {
        logic sat;
        Q15   val;
    } SatQ15;

    function automatic SatQ15 satQ15(input logic signed [SAT_W-1:0] v);
        SatQ15 r;
        if (v > 64'sd32767) begin
            r.sat = 1'b1;
            r.val = Q15_MAX;
        end else if (v < -64'sd32768) begin
            r.sat = 1'b1;
            r.val = Q15_MIN;
        end else begin
            r.sat = 1'b0;
            r.val = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/cplx_q15_mac_mul_pipe.sv
// Two-stage complex Q15 multiplier: S1 partial products, S2 combined Q30 product
// sign-extended to the accumulator width. Every register advances only on i_en.
module cplx_q15_mul_pipe
    import Q15Types::*;
#(
    parameter int unsigned ACC_W = 41
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    i_en,
    input  logic                    i_valid,
    input  logic                    i_last,
    input  CplxQ15                  i_a,
    input  CplxQ15                  i_b,
    output logic                    o_valid,
    output logic                    o_last,
    output logic signed [ACC_W-1:0] o_pr,
    output logic signed [ACC_W-1:0] o_pi
);

    Q30P  r_rr;
    Q30P  r_ii;
    Q30P  r_ri;
    Q30P  r_ir;
    logic r_s1_valid;
    logic r_s1_last;

    logic signed [ACC_W-1:0] r_pr;
    logic signed [ACC_W-1:0] r_pi;
    logic                    r_s2_valid;
    logic                    r_s2_last;

    logic signed [32:0] w_pr;
    logic signed [32:0] w_pi;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_rr       <= '0;
            r_ii       <= '0;
            r_ri       <= '0;
            r_ir       <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else if (i_en) begin
            r_rr       <= i_a.re * i_b.re;
            r_ii       <= i_a.im * i_b.im;
            r_ri       <= i_a.re * i_b.im;
            r_ir       <= i_a.im * i_b.re;
            r_s1_valid <= i_valid;
            r_s1_last  <= i_last;
        end
    end

    // -32768*-32768 twice overflows 32 bits, hence the 33-bit sum/difference.
    always_comb begin
        w_pr = 33'(r_rr) - 33'(r_ii);
        w_pi = 33'(r_ri) + 33'(r_ir);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_pr       <= '0;
            r_pi       <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
        end else if (i_en) begin
            r_pr       <= ACC_W'(w_pr);
            r_pi       <= ACC_W'(w_pi);
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
        end
    end

    always_comb begin
        o_valid = r_s2_valid;
        o_last  = r_s2_last;
        o_pr    = r_pr;
        o_pi    = r_pi;
    end

endmodule

// File: rtl/cplx_q15_mac.sv
// Streaming complex Q15 multiply-accumulate: per-frame Q30 accumulation, Q15 saturated
// result under valid/ready. Define CPLX_Q15_MAC_ROUND_EN for round-half-up instead of truncation.
module cplx_q15_mac
    import Q15Types::*;
#(
    parameter int unsigned GUARD = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_c,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_cnt
);

    localparam int unsigned ACC_W = 33 + GUARD;

    logic w_en;

    logic                    w_s2_valid;
    logic                    w_s2_last;
    logic signed [ACC_W-1:0] w_s2_pr;
    logic signed [ACC_W-1:0] w_s2_pi;

    logic signed [ACC_W-1:0] r_acc_re;
    logic signed [ACC_W-1:0] r_acc_im;
    logic                    r_first;
    logic [CNT_W-1:0]        r_cnt;

    logic signed [ACC_W-1:0] r_fin_re;
    logic signed [ACC_W-1:0] r_fin_im;
    logic [CNT_W-1:0]        r_fin_cnt;
    logic                    r_fin_valid;

    logic                    r_out_valid;
    CplxQ15                  r_out_c;
    logic                    r_out_sat;
    logic [CNT_W-1:0]        r_out_cnt;

    logic signed [ACC_W-1:0] w_sum_re;
    logic signed [ACC_W-1:0] w_sum_im;
    logic [CNT_W-1:0]        w_cnt_base;
    logic [CNT_W-1:0]        w_cnt_inc;

    logic signed [ACC_W:0]   w_ext_re;
    logic signed [ACC_W:0]   w_ext_im;
    logic signed [ACC_W:0]   w_y_re;
    logic signed [ACC_W:0]   w_y_im;
    SatQ15                   w_q_re;
    SatQ15                   w_q_im;

    assign w_en     = !(r_out_valid && !out_ready);
    assign in_ready = w_en;

    cplx_q15_mul_pipe #(
        .ACC_W(ACC_W)
    ) u_mul (
        .clk     (clk),
        .arst    (arst),
        .i_en    (w_en),
        .i_valid (in_valid),
        .i_last  (in_last),
        .i_a     (in_a),
        .i_b     (in_b),
        .o_valid (w_s2_valid),
        .o_last  (w_s2_last),
        .o_pr    (w_s2_pr),
        .o_pi    (w_s2_pi)
    );

    always_comb begin
        w_sum_re   = (r_first ? '0 : r_acc_re) + w_s2_pr;
        w_sum_im   = (r_first ? '0 : r_acc_im) + w_s2_pi;
        w_cnt_base = r_first ? '0 : r_cnt;
        w_cnt_inc  = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(1);
    end

    // S3: accumulate; a closing beat hands its sum to the scaling stage and re-arms the frame.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_first     <= 1'b1;
            r_cnt       <= '0;
            r_fin_re    <= '0;
            r_fin_im    <= '0;
            r_fin_cnt   <= '0;
            r_fin_valid <= 1'b0;
        end else if (w_en) begin
            r_fin_valid <= w_s2_valid && w_s2_last;
            if (w_s2_valid) begin
                if (w_s2_last) begin
                    r_fin_re  <= w_sum_re;
                    r_fin_im  <= w_sum_im;
                    r_fin_cnt <= w_cnt_inc;
                    r_acc_re  <= '0;
                    r_acc_im  <= '0;
                    r_first   <= 1'b1;
                    r_cnt     <= '0;
                end else begin
                    r_acc_re  <= w_sum_re;
                    r_acc_im  <= w_sum_im;
                    r_first   <= 1'b0;
                    r_cnt     <= w_cnt_inc;
                end
            end
        end
    end

    // One extra bit so the rounding offset cannot wrap the accumulator value.
    always_comb begin
        w_ext_re = (ACC_W+1)'(r_fin_re);
        w_ext_im = (ACC_W+1)'(r_fin_im);
`ifdef CPLX_Q15_MAC_ROUND_EN
        w_y_re = (w_ext_re + $signed({{(ACC_W-14){1'b0}}, 1'b1, 14'b0})) >>> 15;
        w_y_im = (w_ext_im + $signed({{(ACC_W-14){1'b0}}, 1'b1, 14'b0})) >>> 15;
`else
        w_y_re = w_ext_re >>> 15;
        w_y_im = w_ext_im >>> 15;
`endif
        w_q_re = satQ15(SAT_W'(w_y_re));
        w_q_im = satQ15(SAT_W'(w_y_im));
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_out_valid <= 1'b0;
            r_out_c     <= '0;
            r_out_sat   <= 1'b0;
            r_out_cnt   <= '0;
        end else if (w_en) begin
            r_out_valid <= r_fin_valid;
            if (r_fin_valid) begin
                r_out_c.re <= w_q_re.val;
                r_out_c.im <= w_q_im.val;
                r_out_sat  <= w_q_re.sat || w_q_im.sat;
                r_out_cnt  <= r_fin_cnt;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_c     = r_out_c;
    assign out_sat   = r_out_sat;
    assign out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_cplx_q15_mac.sv
// Scoreboard bench for cplx_q15_mac: directed vectors with hand-computed results,
// backpressure, mid-frame reset and randomized frames checked against an integer model.
module tb_cplx_q15_mac;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_c;
    logic        out_sat;
    logic [15:0] out_cnt;

    int errors = 0;
    int checks = 0;
    logic rand_bp = 1'b0;

    typedef struct packed {
        logic [31:0] c;
        logic        sat;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    cplx_q15_mac #(.GUARD(8), .CNT_W(16)) dut (
        .clk       (clk),
        .arst      (arst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_sat   (out_sat),
        .out_cnt   (out_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cx(input int re, input int im);
        logic [31:0] r;
        r = {re[15:0], im[15:0]};
        return r;
    endfunction

    function automatic logic [16:0] sat1(input longint v);
        longint y;
`ifdef CPLX_Q15_MAC_ROUND_EN
        y = (v + 64'sd16384) >>> 15;
`else
        y = v >>> 15;
`endif
        if (y > 32767) return {1'b1, 16'h7FFF};
        if (y < -32768) return {1'b1, 16'h8000};
        return {1'b0, y[15:0]};
    endfunction

    task automatic push(input logic [31:0] c, input logic sat, input logic [15:0] cnt);
        exp_t e;
        e.c = c;
        e.sat = sat;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic finish_now();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "bench aborted");
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
        int   n;
        logic ok;
        n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_last = last;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!ok && n > 2000) begin
                errors++;
                checks++;
                $display("FAIL in_ready_timeout: in_ready stuck at %b, required 1", in_ready);
                finish_now();
            end
        end while (!ok);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!arst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got c=%h cnt=%0d, required none", out_c, out_cnt);
            end else begin
                mon_e = sb.pop_front();
                check("out_c", 64'(out_c), 64'(mon_e.c));
                check("out_sat", 64'(out_sat), 64'(mon_e.sat));
                check("out_cnt", 64'(out_cnt), 64'(mon_e.cnt));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : main
        logic [31:0] held;
        int          n;
        int          seed;
        int          len;
        int          ar, ai, br, bi;
        longint      acc_re, acc_im;
        logic [16:0] qr, qi;

        seed = 12345;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_c", 64'(out_c), 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_out_cnt", 64'(out_cnt), 64'd0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single beat plus latency: out_valid must rise exactly after the third edge.
        send_beat(cx(16384, 0), cx(16384, 0), 1'b1);
        push(cx(8192, 0), 1'b0, 16'd1);
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("latency_early", 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        check("latency_due", 64'(out_valid), 64'd1);
        drain();

        send_beat(cx(0, 16384), cx(0, 16384), 1'b1);
        push(cx(-8192, 0), 1'b0, 16'd1);
        send_beat(cx(16384, 16384), cx(16384, -16384), 1'b1);
        push(cx(16384, 0), 1'b0, 16'd1);
        for (int k = 0; k < 4; k++) send_beat(cx(16384, 0), cx(16384, 0), k == 3);
        push(cx(32767, 0), 1'b1, 16'd4);
        send_beat(cx(0, 0), cx(0, 0), 1'b1);
        push(cx(0, 0), 1'b0, 16'd1);
        send_beat(cx(1, 0), cx(16384, 0), 1'b1);
`ifdef CPLX_Q15_MAC_ROUND_EN
        push(cx(1, 0), 1'b0, 16'd1);
`else
        push(cx(0, 0), 1'b0, 16'd1);
`endif
        send_beat(cx(-1, 0), cx(16384, 0), 1'b1);
`ifdef CPLX_Q15_MAC_ROUND_EN
        push(cx(0, 0), 1'b0, 16'd1);
`else
        push(cx(-1, 0), 1'b0, 16'd1);
`endif
        in_valid = 1'b0;
        drain();

        // Backpressure: outputs pile up while out_ready is low.
        out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 6; k++) begin
                    send_beat(cx(k * 1000, 0), cx(16384, 0), 1'b1);
                    push(cx(k * 500, 0), 1'b0, 16'd1);
                end
                in_valid = 1'b0;
            end
        join_none
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        held = out_c;
        repeat (5) begin
            @(negedge clk);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_c", 64'(out_c), 64'(held));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait fork;
        drain();

        // Mid-frame reset: two beats in flight are discarded.
        send_beat(cx(20000, 300), cx(20000, -700), 1'b0);
        send_beat(cx(-12000, 5), cx(9000, 9000), 1'b0);
        in_valid = 1'b0;
        arst = 1'b1;
        @(posedge clk);
        #1;
        arst = 1'b0;
        send_beat(cx(16384, 0), cx(16384, 0), 1'b1);
        push(cx(8192, 0), 1'b0, 16'd1);
        in_valid = 1'b0;
        drain();

        // Random frames, in_valid held high across beats, random output backpressure.
        rand_bp = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            len = $dist_uniform(seed, 1, 8);
            acc_re = 0;
            acc_im = 0;
            for (int k = 0; k < len; k++) begin
                ar = $dist_uniform(seed, -32768, 32767);
                ai = $dist_uniform(seed, -32768, 32767);
                br = $dist_uniform(seed, -32768, 32767);
                bi = $dist_uniform(seed, -32768, 32767);
                acc_re += longint'(ar) * br - longint'(ai) * bi;
                acc_im += longint'(ar) * bi + longint'(ai) * br;
                send_beat(cx(ar, ai), cx(br, bi), k == len - 1);
            end
            qr = sat1(acc_re);
            qi = sat1(acc_im);
            push({qr[15:0], qi[15:0]}, qr[16] | qi[16], 16'(len));
        end
        in_valid = 1'b0;
        rand_bp = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
